fir_frame_sequencer: RTL and testbench
======================================

Name: fir_frame_sequencer

Overview:
Frame-level controller placed in front of and behind the pipelined 16-tap band-pass FIR core. On a command it admits exactly cmd_len upstream samples into the core, then injects FLUSH_LEN zero samples to drain the filter tail. It forwards exactly cmd_len+FLUSH_LEN core results downstream, marks the last one with m_last, and pulses done. Core results that arrive outside a frame are discarded and flagged.

Parameters:
IN_W, 16, input sample width (params_pkg::in_t)
OUT_W, 16, output sample width (params_pkg::out_t)
LEN_W, 16, width of cmd_len
FLUSH_LEN, 15, zero samples injected after each frame (NUM_TAPS-1); 0 allowed

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  frame command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_len  in  LEN_W  frame length in samples
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream sample ready
s_data  in  IN_W  upstream sample
c_s_valid  out  1  sample valid to core
c_s_ready  in  1  core input ready
c_s_data  out  IN_W  sample to core
c_m_valid  in  1  core result valid
c_m_ready  out  1  core result ready
c_m_data  in  OUT_W  core result
m_valid  out  1  downstream result valid
m_ready  in  1  downstream ready
m_data  out  OUT_W  downstream result
m_last  out  1  final result of frame
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse after the final result handshake
stray_err  out  1  sticky: core result seen while IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, in_cnt=0, flush_cnt=0, out_cnt=0, done=0, stray_err=0. All combinational outputs take their IDLE values.
- IDLE values: cmd_ready=1, s_ready=0, c_s_valid=0, c_s_data=0, m_valid=0, m_last=0, busy=0, c_m_ready=1.
- Reset mid-frame aborts the frame with no done pulse. Integration drives the core's rst_n = ~rst, so the core resets together with this block.
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE: on a cmd handshake, latch len and set total = len+FLUSH_LEN using CNT_W = LEN_W+1 bits, so there is no overflow. Counters clear.
  - len>0: go to FEED.
  - len==0: stay IDLE and pulse done on the next cycle. No data moves.
- FEED:
  - Path is combinational: c_s_valid=s_valid, c_s_data=s_data, s_ready=c_s_ready.
  - in_cnt increments on each s handshake.
  - On the handshake with in_cnt==len-1: go to FLUSH, or to DRAIN if FLUSH_LEN==0.
- FLUSH:
  - s_ready=0, c_s_valid=1, c_s_data=0. flush_cnt increments on each c_s handshake.
  - On the handshake with flush_cnt==FLUSH_LEN-1: go to DRAIN.
- DRAIN: no core input (c_s_valid=0, s_ready=0).
- Output side, in any non-IDLE state:
  - m_valid=c_m_valid, m_data=c_m_data, c_m_ready=m_ready.
  - out_cnt increments on each m handshake.
  - m_last = m_valid & (out_cnt==total-1).
- Frame completion: on the m handshake with m_last=1, from any active state, go to IDLE. done=1 on the following cycle. cmd_ready is 1 in that same following cycle, so back-to-back frames are allowed.
- Early final result: if the final result handshakes before input/flush counting completes (a core model with combinational latency), completion still takes effect. The remaining input counters are discarded.
- IDLE output side: c_m_ready=1. Any c_m_valid is dropped (m_valid=0) and stray_err is set to 1; only rst clears it.
- Commands while busy: cmd_ready=0; the command is held off, not lost.
- Simultaneous events: a last-input handshake and an output handshake in the same cycle are both counted. No combinational path exists from m_ready to s_ready.

Decomposition:
- params_pkg gains: FLUSH_LEN = NUM_TAPS-1; len_t = logic[LEN_W-1:0]; cnt_t = logic[LEN_W:0]; seq_state_e enum {IDLE, FEED, FLUSH, DRAIN}.
- Single module, no sub-module. The top-level wrapper instantiates the sequencer in front of algorithm_core.

Test Plan:
- cmd_len=4, s_data 1,2,3,4, m_ready=1 -> core sees 1,2,3,4 then 15 zeros; 19 results out; m_last only on the 19th; done high exactly one cycle later; busy low afterwards.
- cmd_len=0 -> c_s_valid never asserts, m_valid never asserts, done pulses the cycle after the cmd handshake, cmd_ready stays 1.
- cmd_len=8 with m_ready random 50% and s_valid random 50% -> exactly 23 results, no duplicates or drops, matches the golden FIR; s_ready=0 throughout FLUSH.
- cmd_valid held high during a frame with cmd_len=5 -> cmd_ready=0 until the cycle after the final handshake, then the second command is accepted and runs 20 results.
- rst pulsed for one cycle during FLUSH (flush_cnt=7) -> next cycle busy=0, m_valid=0, no done; a new cmd_len=2 produces 17 results.
- Core forced to assert c_m_valid while IDLE -> m_valid stays 0, c_m_ready=1, stray_err=1 and remains set until rst.

Source files
------------

// File: rtl/fir_frame_sequencer_pkg.sv
// Shared constants and types for the FIR frame sequencer and its neighbours.
package fir_frame_sequencer_pkg;
    localparam int NUM_TAPS  = 16;
    localparam int FLUSH_LEN = NUM_TAPS - 1;
    localparam int IN_W      = 16;
    localparam int OUT_W     = 16;
    localparam int LEN_W     = 16;

    typedef logic [IN_W-1:0]  in_t;
    typedef logic [OUT_W-1:0] out_t;
    typedef logic [LEN_W-1:0] len_t;
    typedef logic [LEN_W:0]   cnt_t;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} seq_state_e;
endpackage

// File: rtl/fir_frame_sequencer.sv
// Frame controller around the FIR core: admits cmd_len samples, injects FLUSH_LEN
// zeros to drain the filter tail, and forwards exactly cmd_len+FLUSH_LEN results.
module fir_frame_sequencer #(
    parameter int IN_W      = fir_frame_sequencer_pkg::IN_W,
    parameter int OUT_W     = fir_frame_sequencer_pkg::OUT_W,
    parameter int LEN_W     = fir_frame_sequencer_pkg::LEN_W,
    parameter int FLUSH_LEN = fir_frame_sequencer_pkg::FLUSH_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             c_s_valid,
    input  logic             c_s_ready,
    output logic [IN_W-1:0]  c_s_data,
    input  logic             c_m_valid,
    output logic             c_m_ready,
    input  logic [OUT_W-1:0] c_m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             stray_err
);
    import fir_frame_sequencer_pkg::*;

    // One extra bit so len+FLUSH_LEN never wraps.
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] FLUSH_CNT  = CNT_W'(FLUSH_LEN);
    localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_LEN > 0) ? CNT_W'(FLUSH_LEN - 1) : '0;

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] out_cnt;

    logic cmd_fire;
    logic s_fire;
    logic cs_fire;
    logic m_fire;
    logic last_fire;
    logic in_last;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign s_fire    = s_valid & s_ready;
    assign cs_fire   = c_s_valid & c_s_ready;
    assign m_fire    = m_valid & m_ready;
    assign last_fire = m_fire & m_last;
    assign in_last   = (in_cnt == ({1'b0, len_q} - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Final result handshake wins over any input-side transition, so a core
    // with combinational latency can finish the frame before counting ends.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_fire && cmd_len != '0) state_nxt = FEED;
            FEED:    if (s_fire && in_last) state_nxt = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
            FLUSH:   if (cs_fire && flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
            default: ;
        endcase
        if (state != IDLE && last_fire) state_nxt = IDLE;
    end

    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        c_s_valid = 1'b0;
        c_s_data  = '0;
        c_m_ready = 1'b1;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: cmd_ready = 1'b1;
            FEED: begin
                c_s_valid = s_valid;
                c_s_data  = s_data;
                s_ready   = c_s_ready;
            end
            FLUSH:   c_s_valid = 1'b1;
            default: ;
        endcase
        if (state != IDLE) begin
            m_valid   = c_m_valid;
            m_data    = c_m_data;
            c_m_ready = m_ready;
            m_last    = c_m_valid & (out_cnt == total_q - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt    <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
            done      <= 1'b0;
            stray_err <= 1'b0;
        end else begin
            done <= last_fire | (cmd_fire & (cmd_len == '0));
            if (state == IDLE) begin
                if (c_m_valid) stray_err <= 1'b1;
                if (cmd_fire) begin
                    in_cnt    <= '0;
                    flush_cnt <= '0;
                    out_cnt   <= '0;
                end
            end else begin
                if (s_fire) in_cnt <= in_cnt + 1'b1;
                if (state == FLUSH && cs_fire) flush_cnt <= flush_cnt + 1'b1;
                if (m_fire) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            len_q   <= cmd_len;
            total_q <= {1'b0, cmd_len} + FLUSH_CNT;
        end
    end
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer with a behavioural 16-tap FIR core model.
`timescale 1ns/1ps
module tb_fir_frame_sequencer;
    localparam int IN_W = 16, OUT_W = 16, LEN_W = 16, FLUSH_LEN = 15, NTAPS = 16;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic s_valid, s_ready;
    logic [IN_W-1:0] s_data;
    logic c_s_valid, c_s_ready;
    logic [IN_W-1:0] c_s_data;
    logic c_m_valid, c_m_ready;
    logic [OUT_W-1:0] c_m_data;
    logic m_valid, m_ready, m_last;
    logic [OUT_W-1:0] m_data;
    logic busy, done, stray_err;

    always #5 clk = ~clk;

    fir_frame_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .c_s_valid(c_s_valid), .c_s_ready(c_s_ready), .c_s_data(c_s_data),
        .c_m_valid(c_m_valid), .c_m_ready(c_m_ready), .c_m_data(c_m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .stray_err(stray_err)
    );

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t            exp_q[$];
    logic [IN_W-1:0] feed_q[$];
    logic [IN_W-1:0] exp_core[$];
    int checks = 0;
    int errors = 0;
    int h[NTAPS] = '{3, -1, 4, -1, 5, -9, 2, 6, -5, 3, 5, -8, 9, -7, 9, 3};
    bit s_rand = 0, cs_rand = 0, mr_rand = 0, junk_s = 0, inject_stray = 0;
    int core_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: full frame convolution from a zero history, inputs then flush zeros.
    task automatic start_frame(input int len, input bit ramp);
        logic [IN_W-1:0] smp;
        int x[$];
        int acc;
        exp_t e;
        if (len == 0) return;
        for (int i = 0; i < len; i++) begin
            smp = ramp ? IN_W'(i + 1) : IN_W'($urandom);
            feed_q.push_back(smp);
            exp_core.push_back(smp);
            x.push_back(int'($signed(smp)));
        end
        for (int i = 0; i < FLUSH_LEN; i++) begin
            exp_core.push_back('0);
            x.push_back(0);
        end
        for (int n = 0; n < len + FLUSH_LEN; n++) begin
            acc = 0;
            for (int k = 0; k < NTAPS; k++) if (n >= k) acc += h[k] * x[n - k];
            e.data = acc[OUT_W-1:0];
            e.last = (n == len + FLUSH_LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_cmd(input int len, output int waited, output bit done_at_acc);
        bit acc_seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(len);
        waited = 0;
        done_at_acc = 0;
        acc_seen = 0;
        while (!acc_seen && waited <= 2000) begin
            @(posedge clk);
            check("cmd_ready_vs_busy", cmd_ready, !busy);
            if (cmd_ready) begin
                acc_seen = 1;
                done_at_acc = done;
            end else begin
                waited++;
            end
        end
        if (!acc_seen) fail("cmd_accept_timeout");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail(name);
    endtask

    // Core model: one-cycle registered FIR with a result FIFO.
    initial begin
        int hist[NTAPS];
        int acc;
        bit stray_now;
        logic [OUT_W-1:0] cq[$];
        logic [IN_W-1:0] e;
        hist = '{default: 0};
        stray_now = 0;
        c_s_ready = 1'b1;
        c_m_valid = 1'b0;
        c_m_data = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cq.delete();
                hist = '{default: 0};
            end else begin
                if (c_m_valid && c_m_ready && !stray_now) void'(cq.pop_front());
                if (c_s_valid && c_s_ready) begin
                    core_acc++;
                    if (exp_core.size() == 0) fail("core_in_extra");
                    else begin
                        e = exp_core.pop_front();
                        check("core_in", c_s_data, e);
                    end
                    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = int'($signed(c_s_data));
                    acc = 0;
                    for (int k = 0; k < NTAPS; k++) acc += h[k] * hist[k];
                    cq.push_back(acc[OUT_W-1:0]);
                end
            end
            @(negedge clk);
            c_s_ready = cs_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            stray_now = inject_stray;
            if (stray_now) begin
                c_m_valid = 1'b1;
                c_m_data = 16'hDEAD;
            end else begin
                c_m_valid = (cq.size() > 0);
                c_m_data = (cq.size() > 0) ? cq[0] : '0;
            end
        end
    end

    // Upstream source: offers queued samples, or junk when nothing is queued.
    initial begin
        s_valid = 1'b0;
        s_data = '0;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0) begin
                s_valid = s_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data = feed_q[0];
            end else begin
                s_valid = junk_s;
                s_data = IN_W'($urandom);
            end
            @(posedge clk);
            if (!rst && s_valid && s_ready) begin
                if (feed_q.size() > 0) void'(feed_q.pop_front());
                else fail("s_extra_handshake");
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor and done-pulse tracker.
    initial begin
        exp_t e;
        bit exp_done;
        exp_done = 0;
        forever begin
            @(posedge clk);
            if (done || exp_done) check("done_pulse", done, exp_done);
            if (rst) exp_done = 0;
            else begin
                exp_done = cmd_valid && cmd_ready && (cmd_len == '0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) fail("m_extra_output");
                    else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_last", m_last, e.last);
                        if (e.last) exp_done = 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, base, n;
        bit d;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_s_ready", s_ready, 0);
        check("rst_c_s_valid", c_s_valid, 0);
        check("rst_c_s_data", c_s_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_c_m_ready", c_m_ready, 1);
        check("rst_done", done, 0);
        check("rst_stray", stray_err, 0);
        rst = 1'b0;

        // Ramp frame, everything always ready.
        start_frame(4, 1);
        issue_cmd(4, w, d);
        wait_done("t1_done_timeout");
        check("t1_busy_at_done", busy, 0);
        @(negedge clk);
        check("t1_done_width", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_left", exp_q.size(), 0);

        // Zero-length command.
        issue_cmd(0, w, d);
        check("t2_done", done, 1);
        check("t2_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("t2_c_s_valid", c_s_valid, 0);
            check("t2_m_valid", m_valid, 0);
            check("t2_busy", busy, 0);
            @(negedge clk);
        end

        // Random backpressure on all sides, junk offered after the frame's inputs.
        s_rand = 1; cs_rand = 1; mr_rand = 1; junk_s = 1;
        start_frame(8, 0);
        issue_cmd(8, w, d);
        wait_done("t3_done_timeout");
        @(negedge clk);
        check("t3_left", exp_q.size(), 0);

        // Command held during a frame: accepted in the done cycle.
        s_rand = 0; cs_rand = 0; mr_rand = 0; junk_s = 0;
        start_frame(5, 0);
        start_frame(5, 0);
        issue_cmd(5, w, d);
        issue_cmd(5, w, d);
        check("t4_held_off", (w > 0), 1);
        check("t4_accept_in_done_cycle", d, 1);
        wait_done("t4_done_timeout");
        @(negedge clk);
        check("t4_left", exp_q.size(), 0);

        // Reset mid-flush after 7 zero samples.
        base = core_acc;
        start_frame(3, 0);
        issue_cmd(3, w, d);
        n = 0;
        while (core_acc < base + 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (core_acc != base + 10) fail("t5_flush_reach");
        check("t5_busy_before", busy, 1);
        rst = 1'b1;
        feed_q.delete();
        exp_q.delete();
        exp_core.delete();
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_m_valid", m_valid, 0);
        check("t5_done", done, 0);
        @(negedge clk);
        check("t5_done_next", done, 0);
        start_frame(2, 0);
        issue_cmd(2, w, d);
        wait_done("t5_done_timeout");
        @(negedge clk);
        check("t5_left", exp_q.size(), 0);

        // Random frames and modes.
        for (int f = 0; f < 5; f++) begin
            s_rand = 1'($urandom_range(0, 1));
            cs_rand = 1'($urandom_range(0, 1));
            mr_rand = 1'($urandom_range(0, 1));
            junk_s = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 20);
            start_frame(n, 0);
            issue_cmd(n, w, d);
            wait_done("rand_done_timeout");
            @(negedge clk);
            check("rand_left", exp_q.size(), 0);
        end
        s_rand = 0; cs_rand = 0; mr_rand = 0; junk_s = 0;

        // Stray core output while idle.
        repeat (2) @(negedge clk);
        check("t6_stray_before", stray_err, 0);
        inject_stray = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_m_valid", m_valid, 0);
            check("t6_c_m_ready", c_m_ready, 1);
        end
        inject_stray = 0;
        repeat (2) @(negedge clk);
        check("t6_stray_set", stray_err, 1);
        start_frame(2, 0);
        issue_cmd(2, w, d);
        wait_done("t6_done_timeout");
        @(negedge clk);
        check("t6_stray_sticky", stray_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_stray_cleared", stray_err, 0);

        check("end_feed_left", feed_q.size(), 0);
        check("end_core_left", exp_core.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
